mips_multicycle_control_unit: RTL and testbench

Finite-state controller for the multicycle MIPS datapath: the next generation of the single-cycle control unit. It sequences each instruction through fetch, decode, execute, memory and writeback steps over 3–5 clocks, sharing one ALU and one memory port. It sits between the instruction register (opcode/funct) and the multicycle datapath muxes, register file and unified memory. ALU control width is parametrised, and an optional memory-ready handshake lets it stall on slow memory.

---
 rtl/mips_multicycle_control_unit.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_control_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_unit.sv
// Multicycle MIPS FSM controller: fetch/decode/execute/memory/writeback sequencing.
// Define MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on a low mem_ready.
module mips_multicycle_control_unit #(
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  Branch,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  MemToReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal_op,
  output logic                  instr_done,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   fn_bad;
  logic [ALU_CTRL_W-1:0] alu_fn;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign state = state_q;

  // Unknown funct falls back to ADD so the instruction still retires.
  always_comb begin
    alu_fn = ALU_ADD;
    fn_bad = 1'b0;
    unique case (funct)
      6'h20:   alu_fn = ALU_ADD;
      6'h22:   alu_fn = ALU_SUB;
      6'h24:   alu_fn = ALU_AND;
      6'h25:   alu_fn = ALU_OR;
      6'h2A:   alu_fn = ALU_SLT;
      default: fn_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = ALU_AND;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        IRWrite    = mem_rdy;
        PCWrite    = mem_rdy;
        state_d    = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_rdy;
        state_d    = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_fn;
        illegal_op = fn_bad;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        ALUControl = alu_fn;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control_unit.sv
// Directed-vector bench for mips_multicycle_control_unit.
// Expected control words are hand-written per state and instruction.
module tb_mips_multicycle_control_unit;

  localparam logic [4:0] A_AND = 5'b00000;
  localparam logic [4:0] A_OR  = 5'b00001;
  localparam logic [4:0] A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b00110;
  localparam logic [4:0] A_SLT = 5'b00111;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;

  mips_multicycle_control_unit #(.ALU_CTRL_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .Branch(Branch),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  // pcw br iord mw irw rd m2r rw sa sb ps alu ill dn
  logic [19:0] ctl;
  assign ctl = {PCWrite, Branch, IorD, MemWrite, IRWrite, RegDst,
                MemToReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
                ALUControl, illegal_op, instr_done};

  function automatic logic [19:0] cw(
    input logic pcw, br, iord, mw, irw, rd, m2r, rw, sa,
    input logic [1:0] sb, ps, input logic [4:0] alu,
    input logic ill, dn);
    return {pcw, br, iord, mw, irw, rd, m2r, rw, sa, sb, ps, alu, ill, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Check state and control word now, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [19:0] c);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    @(posedge clk);
    #1;
  endtask

  logic [19:0] C_FETCH, C_DEC, C_DEC_ILL, C_MADR, C_MRD, C_MWB;
  logic [19:0] C_MWR, C_BR, C_AEX, C_AWB, C_J, C_FSTALL, C_MWR_W;

  task automatic run_r(input string tag, input logic [5:0] fn,
                       input logic [4:0] alu, input logic ill);
    opcode = 6'h00;
    funct  = fn;
    cyc({tag, ".F"}, 4'd1, C_FETCH);
    cyc({tag, ".D"}, 4'd2, C_DEC);
    cyc({tag, ".EX"}, 4'd7,
        cw(0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu,ill,0));
    cyc({tag, ".WB"}, 4'd8,
        cw(0,0,0,0,0,1,0,1,0,2'b00,2'b00,alu,0,1));
  endtask

  initial begin
    C_FETCH   = cw(1,0,0,0,1,0,0,0,0,2'b01,2'b00,A_ADD,0,0);
    C_FSTALL  = cw(0,0,0,0,0,0,0,0,0,2'b01,2'b00,A_ADD,0,0);
    C_DEC     = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,0,0);
    C_DEC_ILL = cw(0,0,0,0,0,0,0,0,0,2'b11,2'b00,A_ADD,1,1);
    C_MADR    = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0,0);
    C_MRD     = cw(0,0,1,0,0,0,0,0,0,2'b00,2'b00,A_AND,0,0);
    C_MWB     = cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,A_AND,0,1);
    C_MWR     = cw(0,0,1,1,0,0,0,0,0,2'b00,2'b00,A_AND,0,1);
    C_MWR_W   = cw(0,0,1,1,0,0,0,0,0,2'b00,2'b00,A_AND,0,0);
    C_BR      = cw(0,1,0,0,0,0,0,0,1,2'b00,2'b01,A_SUB,0,1);
    C_AEX     = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,A_ADD,0,0);
    C_AWB     = cw(0,0,0,0,0,0,0,1,0,2'b00,2'b00,A_AND,0,1);
    C_J       = cw(1,0,0,0,0,0,0,0,0,2'b00,2'b10,A_AND,0,1);

    rst = 1'b1; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.state", 32'(state), 32'd0);
    check("reset.ctl", 32'(ctl), 32'd0);
    rst = 1'b0;
    cyc("rel.idle", 4'd0, 20'd0);

    opcode = 6'h23;
    cyc("lw.F", 4'd1, C_FETCH);
    cyc("lw.D", 4'd2, C_DEC);
    cyc("lw.MA", 4'd3, C_MADR);
    cyc("lw.RD", 4'd4, C_MRD);
    cyc("lw.WB", 4'd5, C_MWB);

    run_r("slt", 6'h2A, A_SLT, 1'b0);
    run_r("sub", 6'h22, A_SUB, 1'b0);
    run_r("and", 6'h24, A_AND, 1'b0);
    run_r("or",  6'h25, A_OR,  1'b0);

    opcode = 6'h04;
    cyc("beq.F", 4'd1, C_FETCH);
    cyc("beq.D", 4'd2, C_DEC);
    cyc("beq.BR", 4'd9, C_BR);
    opcode = 6'h02;
    cyc("j.F", 4'd1, C_FETCH);
    cyc("j.D", 4'd2, C_DEC);
    cyc("j.J", 4'd12, C_J);

    opcode = 6'h08;
    cyc("addi.F", 4'd1, C_FETCH);
    cyc("addi.D", 4'd2, C_DEC);
    cyc("addi.EX", 4'd10, C_AEX);
    cyc("addi.WB", 4'd11, C_AWB);

    opcode = 6'h3F;
    cyc("ill.F", 4'd1, C_FETCH);
    cyc("ill.D", 4'd2, C_DEC_ILL);

    run_r("badfn", 6'h3F, A_ADD, 1'b1);

`ifdef MEM_WAIT_EN
    opcode = 6'h2B;
    mem_ready = 1'b0;
    cyc("sww.Fst", 4'd1, C_FSTALL);
    mem_ready = 1'b1;
    cyc("sww.F", 4'd1, C_FETCH);
    cyc("sww.D", 4'd2, C_DEC);
    cyc("sww.MA", 4'd3, C_MADR);
    mem_ready = 1'b0;
    cyc("sww.W1", 4'd6, C_MWR_W);
    cyc("sww.W2", 4'd6, C_MWR_W);
    cyc("sww.W3", 4'd6, C_MWR_W);
    mem_ready = 1'b1;
    cyc("sww.W4", 4'd6, C_MWR);
    opcode = 6'h23;
    cyc("lww.F", 4'd1, C_FETCH);
    cyc("lww.D", 4'd2, C_DEC);
    cyc("lww.MA", 4'd3, C_MADR);
    mem_ready = 1'b0;
    cyc("lww.RDw", 4'd4, C_MRD);
    mem_ready = 1'b1;
    cyc("lww.RD", 4'd4, C_MRD);
    cyc("lww.WB", 4'd5, C_MWB);
`else
    opcode = 6'h2B;
    mem_ready = 1'b0;
    cyc("sw.F", 4'd1, C_FETCH);
    cyc("sw.D", 4'd2, C_DEC);
    cyc("sw.MA", 4'd3, C_MADR);
    cyc("sw.WR", 4'd6, C_MWR);
    mem_ready = 1'b1;
`endif

    opcode = 6'h00;
    funct  = 6'h20;
    cyc("rst.F", 4'd1, C_FETCH);
    cyc("rst.D", 4'd2, C_DEC);
    #1;
    check("rst.ex", 32'(state), 32'd7);
    rst = 1'b1;
    #1;
    check("rst.async.state", 32'(state), 32'd0);
    check("rst.async.ctl", 32'(ctl), 32'd0);
    @(posedge clk);
    #1;
    check("rst.hold.state", 32'(state), 32'd0);
    check("rst.hold.rw", 32'(RegWrite), 32'd0);
    rst = 1'b0;
    cyc("rst.idle", 4'd0, 20'd0);
    cyc("rst.F2", 4'd1, C_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
